cpu: RTL and testbench
======================

CPU -- requirements
Module: cpu

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have the port pc, output, 16 bits: byte address of the instruction executing this cycle.
REQ-004 The block SHALL have the port hlt, output, 1 bit: high once a HLT instruction has executed.
REQ-005 The block SHALL provide internal probe nets for benches:
- if_instruction: fetched word.
- wb_reg_write, wb_dest_reg[3:0], wb_reg_write_value[15:0]: register write this cycle.
- mem_wr, mem_data_in[15:0] (store data), mem_data_out[15:0] (load data).
- Data array mem inside ram_controller_instance.memory_instance.

Function
REQ-006 Core SHALL be single-cycle:
- One 16-bit instruction per clock; 16 x 16-bit registers; flags Z, V, N.
- Separate instruction and data memories, each 32K words, indexed by address[15:1].
- Both memories are preloaded from hex files at elaboration; contents are not reset.
REQ-007 Encoding SHALL use opcode [15:12]. Field roles:
- rd [11:8], rs [7:4], rt/imm4 [3:0].
- LW/SW: rt [11:8], rs [7:4], signed offset [3:0].
- B: cond [11:9], signed imm9 [8:0].
- BR: cond [11:9], rs [7:4].
- LLB/LHB: rd [11:8], imm8 [7:0].
REQ-008 Opcodes SHALL be:
- 0 ADD, 1 SUB, 2 XOR, 3 AND, 4 SLL, 5 SRA, 6 ROR (shift amount = imm4), 7 OR.
- 8 LW, 9 SW, A LLB, B LHB, C B, D BR, E PCS, F HLT.
REQ-009 ALU results SHALL be 16-bit, with ADD/SUB wrapping modulo 2^16 unless REQ-019 applies.
REQ-010 Flag updates SHALL be:
- Z set by opcodes 0-7.
- N and V set only by ADD/SUB, where V is signed two's-complement overflow.
- All other instructions leave flags unchanged.
REQ-011 Loads and stores SHALL use:
- Effective address = (rs & 0xFFFE) + (sext(offset) << 1).
- LW writes rt; SW writes rt to memory.
- mem_wr is high exactly in the SW cycle.
REQ-012 LLB SHALL compute rd = (rd & 0xFF00) | imm8, and LHB SHALL compute rd = (rd & 0x00FF) | (imm8 << 8).
REQ-013 Branch conditions SHALL be:
- 000 NE: Z=0; 001 EQ: Z=1; 010 GT: Z=0 and N=0; 011 LT: N=1.
- 100 GE: N=0; 101 LE: N=1 or Z=1; 110 OV: V=1; 111 always.
REQ-014 Next PC SHALL be:
- Default: PC+2.
- B taken: PC+2 + (sext(imm9) << 1).
- BR taken: rs.
- PCS: rd = PC+2, then continue at PC+2.
- PC wraps modulo 2^16.
REQ-015 Register 0 SHALL always read 0, and writes to it SHALL be suppressed, including on the wb_reg_write probe.
REQ-016 HLT SHALL behave as follows:
- hlt goes high combinationally in the cycle HLT is fetched.
- pc stops advancing and hlt stays high until reset.
- No register or memory writes occur while halted.

Reset
REQ-017 While rst_n=0, the block SHALL hold pc=0x0000, hlt=0, all registers=0, flags Z=V=N=0, mem_wr=0, and wb_reg_write=0.
REQ-018 When rst_n is asserted mid-instruction, the block SHALL abort that instruction with no write occurring, and SHALL fetch from 0x0000 on the first rising edge after release.

Configuration
REQ-019 Macro SAT_ARITH_EN SHALL control ADD/SUB arithmetic:
- Defined: ADD/SUB saturate to 0x7FFF on positive overflow and 0x8000 on negative overflow, with V still set.
- Undefined: ADD/SUB wrap.

Verification
REQ-020 Reset then LLB R1,0x34; LHB R1,0x12 -> R1=0x1234, pc=0x0004.
REQ-021 R1=0x7FFF, R2=1, ADD R3,R1,R2 -> V=1, N=1. R3=0x8000 without SAT_ARITH_EN; R3=0x7FFF with it.
REQ-022 SW R1,[R0+2] then LW R4,[R0+2] -> mem_wr high in the store cycle only, and R4 equals R1.
REQ-023 SUB R5,R1,R1 then B EQ,+3 at pc 0x0010 -> next pc=0x0018. B NE at the same point -> next pc=0x0012.
REQ-024 HLT at 0x0020 -> hlt=1, pc stays 0x0020 for subsequent cycles, no writes occur.
REQ-025 Assert rst_n=0 mid-program -> pc=0 and hlt=0 immediately, registers cleared.

Source files
------------

// File: rtl/cpu.sv
// Single-cycle 16-bit CPU: 16 registers, Z/V/N flags, split instruction/data memories.
// Optional build macro SAT_ARITH_EN: ADD/SUB saturate on signed overflow instead of wrapping.

module ram_array (
  input  logic        clk,
  input  logic        we_i,
  input  logic [14:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o
);
  // Contents have no reset; the environment loads the hex image into mem.
  logic [15:0] mem [0:32767];

  always_ff @(posedge clk)
    if (we_i) mem[addr_i] <= wdata_i;

  assign rdata_o = mem[addr_i];
endmodule

module ram_controller (
  input  logic        clk,
  input  logic        we_i,
  input  logic [14:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o
);
  ram_array memory_instance (
    .clk     (clk),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o)
  );
endmodule

module cpu (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] pc,
  output logic        hlt
);
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_SLL, OP_SRA, OP_ROR, OP_OR,
    OP_LW,  OP_SW,  OP_LLB, OP_LHB, OP_B,   OP_BR,  OP_PCS, OP_HLT
  } opcode_e;

  logic [15:0] pc_q, pc_d;
  logic        hlt_q;
  logic [15:0] rf_q [16];
  logic        z_q, v_q, n_q;

  logic [15:0] if_instruction;
  logic        wb_reg_write;
  logic [3:0]  wb_dest_reg;
  logic [15:0] wb_reg_write_value;
  logic        mem_wr;
  logic [15:0] mem_data_in, mem_data_out;

  opcode_e     op;
  logic [3:0]  rs, rb_sel, imm4;
  logic [15:0] a_val, b_val, pc_plus2;
  logic [14:0] ea_w;
  logic        run, reg_we_raw, take;

  ram_array imem_instance (
    .clk     (clk),
    .we_i    (1'b0),
    .addr_i  (pc_q[15:1]),
    .wdata_i (16'h0000),
    .rdata_o (if_instruction)
  );

  assign op       = opcode_e'(if_instruction[15:12]);
  assign rs       = if_instruction[7:4];
  assign imm4     = if_instruction[3:0];
  // SW stores, and LLB/LHB merge into, the register named in [11:8].
  assign rb_sel   = (op == OP_SW || op == OP_LLB || op == OP_LHB) ? if_instruction[11:8] : imm4;
  assign a_val    = rf_q[rs];
  assign b_val    = rf_q[rb_sel];
  assign pc_plus2 = pc_q + 16'd2;

  assign hlt = rst_n & (hlt_q | (op == OP_HLT));
  assign run = rst_n & ~hlt;

  // Word address: (rs & ~1) + sext(off) << 1, expressed directly in words.
  assign ea_w        = a_val[15:1] + {{11{if_instruction[3]}}, if_instruction[3:0]};
  assign mem_wr      = run & (op == OP_SW);
  assign mem_data_in = b_val;

  ram_controller ram_controller_instance (
    .clk     (clk),
    .we_i    (mem_wr),
    .addr_i  (ea_w),
    .wdata_i (mem_data_in),
    .rdata_o (mem_data_out)
  );

  logic [15:0] alu_res, wrap;
  logic [31:0] rot32;
  logic        ovf;

  always_comb begin
    wrap  = '0;
    rot32 = '0;
    ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        wrap = a_val + b_val;
        ovf  = (a_val[15] == b_val[15]) && (wrap[15] != a_val[15]);
      end
      OP_SUB: begin
        wrap = a_val - b_val;
        ovf  = (a_val[15] != b_val[15]) && (wrap[15] != a_val[15]);
      end
      OP_XOR: wrap = a_val ^ b_val;
      OP_AND: wrap = a_val & b_val;
      OP_SLL: wrap = a_val << imm4;
      OP_SRA: wrap = $unsigned($signed(a_val) >>> imm4);
      OP_ROR: begin
        rot32 = {a_val, a_val} >> imm4;
        wrap  = rot32[15:0];
      end
      OP_OR:  wrap = a_val | b_val;
      default: wrap = '0;
    endcase
    alu_res = wrap;
`ifdef SAT_ARITH_EN
    // Overflow direction follows the sign of the first operand for both ADD and SUB.
    if (ovf) alu_res = a_val[15] ? 16'h8000 : 16'h7FFF;
`endif
  end

  always_comb begin
    reg_we_raw         = 1'b0;
    wb_reg_write_value = alu_res;
    case (op)
      OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_SLL, OP_SRA, OP_ROR, OP_OR:
        reg_we_raw = 1'b1;
      OP_LW:  begin reg_we_raw = 1'b1; wb_reg_write_value = mem_data_out; end
      OP_LLB: begin reg_we_raw = 1'b1; wb_reg_write_value = {b_val[15:8], if_instruction[7:0]}; end
      OP_LHB: begin reg_we_raw = 1'b1; wb_reg_write_value = {if_instruction[7:0], b_val[7:0]}; end
      OP_PCS: begin reg_we_raw = 1'b1; wb_reg_write_value = pc_plus2; end
      default: reg_we_raw = 1'b0;
    endcase
  end

  assign wb_dest_reg  = if_instruction[11:8];
  assign wb_reg_write = run & reg_we_raw & (wb_dest_reg != 4'd0);

  always_comb begin
    case (if_instruction[11:9])
      3'b000:  take = ~z_q;
      3'b001:  take = z_q;
      3'b010:  take = ~z_q & ~n_q;
      3'b011:  take = n_q;
      3'b100:  take = ~n_q;
      3'b101:  take = n_q | z_q;
      3'b110:  take = v_q;
      default: take = 1'b1;
    endcase
  end

  always_comb begin
    pc_d = pc_plus2;
    if (hlt)
      pc_d = pc_q;
    else if (op == OP_B && take)
      pc_d = pc_plus2 + {{6{if_instruction[8]}}, if_instruction[8:0], 1'b0};
    else if (op == OP_BR && take)
      pc_d = a_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= '0;
      hlt_q <= 1'b0;
      z_q   <= 1'b0;
      v_q   <= 1'b0;
      n_q   <= 1'b0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      hlt_q <= hlt;
      if (wb_reg_write) rf_q[wb_dest_reg] <= wb_reg_write_value;
      if (run && !op[3]) z_q <= (alu_res == 16'h0000);
      if (run && (op == OP_ADD || op == OP_SUB)) begin
        v_q <= ovf;
        n_q <= wrap[15];
      end
    end
  end

  assign pc = pc_q;
endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: loads a small program into instruction memory and checks
// register writes, flags, memory strobes, branching, halt and mid-program reset.

module tb_cpu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc;
  logic        hlt;
  int          errors = 0;
  int          checks = 0;

  cpu dut (.clk(clk), .rst_n(rst_n), .pc(pc), .hlt(hlt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  logic [15:0] prog [17];
  logic [15:0] add_exp;

  initial begin
    prog = '{16'hA134, 16'hB112, 16'hA6FF, 16'hB67F, 16'hA201, 16'h9101, 16'h8401,
             16'h1511, 16'hC203, 16'hA7EE, 16'hA7EE, 16'hA7EE, 16'h0362, 16'hE800,
             16'h2916, 16'h6A14, 16'hF000};
`ifdef SAT_ARITH_EN
    add_exp = 16'h7FFF;
`else
    add_exp = 16'h8000;
`endif
    for (int i = 0; i < 17; i++) dut.imem_instance.mem[i] = prog[i];
    dut.ram_controller_instance.memory_instance.mem[1] = 16'h0000;

    @(negedge clk);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_hlt", {15'd0, hlt}, 16'h0000);
    chk("rst_memwr", {15'd0, dut.mem_wr}, 16'h0000);
    chk("rst_wbwe", {15'd0, dut.wb_reg_write}, 16'h0000);
    chk("rst_r1", dut.rf_q[1], 16'h0000);
    rst_n = 1'b1;
    #1;
    chk("llb_we", {15'd0, dut.wb_reg_write}, 16'h0001);
    chk("llb_val", dut.wb_reg_write_value, 16'h0034);
    step(1);
    chk("lhb_val", dut.wb_reg_write_value, 16'h1234);
    step(1);
    chk("pc_after_lhb", pc, 16'h0004);
    chk("r1", dut.rf_q[1], 16'h1234);
    step(3);
    chk("sw_pc", pc, 16'h000A);
    chk("sw_memwr", {15'd0, dut.mem_wr}, 16'h0001);
    chk("sw_data", dut.mem_data_in, 16'h1234);
    chk("sw_no_regwr", {15'd0, dut.wb_reg_write}, 16'h0000);
    step(1);
    chk("lw_memwr", {15'd0, dut.mem_wr}, 16'h0000);
    chk("lw_data", dut.mem_data_out, 16'h1234);
    chk("lw_dest", {12'd0, dut.wb_dest_reg}, 16'h0004);
    step(1);
    chk("sub_val", dut.wb_reg_write_value, 16'h0000);
    chk("r4", dut.rf_q[4], 16'h1234);
    step(1);
    chk("beq_pc", pc, 16'h0010);
    chk("z_after_sub", {15'd0, dut.z_q}, 16'h0001);
    step(1);
    chk("beq_target", pc, 16'h0018);
    chk("add_val", dut.wb_reg_write_value, add_exp);
    step(1);
    chk("add_v", {15'd0, dut.v_q}, 16'h0001);
    chk("add_n", {15'd0, dut.n_q}, 16'h0001);
    chk("add_z", {15'd0, dut.z_q}, 16'h0000);
    chk("r3", dut.rf_q[3], add_exp);
    chk("pcs_val", dut.wb_reg_write_value, 16'h001C);
    step(1);
    chk("xor_val", dut.wb_reg_write_value, 16'h6DCB);
    step(1);
    chk("ror_val", dut.wb_reg_write_value, 16'h4123);
    step(1);
    chk("hlt_pc", pc, 16'h0020);
    chk("hlt_now", {15'd0, hlt}, 16'h0001);
    chk("hlt_no_regwr", {15'd0, dut.wb_reg_write}, 16'h0000);
    chk("hlt_no_memwr", {15'd0, dut.mem_wr}, 16'h0000);
    step(3);
    chk("hlt_pc_hold", pc, 16'h0020);
    chk("hlt_hold", {15'd0, hlt}, 16'h0001);
    chk("skipped_r7", dut.rf_q[7], 16'h0000);
    chk("r8_pcs", dut.rf_q[8], 16'h001C);
    chk("r10_ror", dut.rf_q[10], 16'h4123);

    // Swap the branch to NE, then reset in the middle of a cycle.
    dut.imem_instance.mem[8] = 16'hC003;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pc", pc, 16'h0000);
    chk("mid_rst_hlt", {15'd0, hlt}, 16'h0000);
    chk("mid_rst_r1", dut.rf_q[1], 16'h0000);
    chk("mid_rst_z", {15'd0, dut.z_q}, 16'h0000);
    chk("mid_rst_wbwe", {15'd0, dut.wb_reg_write}, 16'h0000);
    @(negedge clk);
    chk("held_rst_pc", pc, 16'h0000);
    rst_n = 1'b1;
    step(8);
    chk("bne_pc", pc, 16'h0010);
    chk("bne_z", {15'd0, dut.z_q}, 16'h0001);
    step(1);
    chk("bne_fallthru", pc, 16'h0012);
    chk("fill_val", dut.wb_reg_write_value, 16'h00EE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
